// File: rtl/pipe_add_sub_pkg.sv
// pipe_add_sub_pkg: shared helpers for the pipelined adder/subtractor.
//   seg_width()  - width of one carry-chain segment (N/SEG)
//   params_ok()  - legality of an (N, SEG) pair, used for an elaboration check
//   max_pos()    - most positive N-bit two's-complement value (saturation)
//   min_neg()    - most negative N-bit two's-complement value (saturation)
// The saturation helpers return MAX_N-bit values; callers size-cast to N.
package pipe_add_sub_pkg;

  localparam int MAX_N = 1024;

  function automatic int seg_width(input int n, input int seg);
    return (seg < 1) ? 1 : n / seg;
  endfunction

  function automatic bit params_ok(input int n, input int seg);
    return (n >= 2) && (n <= MAX_N) && (seg >= 1) && (seg <= n) &&
           ((n % seg) == 0);
  endfunction

  function automatic logic [MAX_N-1:0] max_pos(input int n);
    return (MAX_N'(1) << (n - 1)) - MAX_N'(1);
  endfunction

  function automatic logic [MAX_N-1:0] min_neg(input int n);
    return MAX_N'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   a_i, b_i, ci_i : addend bits and carry-in
//   s_o, co_o      : sum bit and carry-out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/pipe_add_sub_add_segment.sv
// add_segment: W-bit ripple-carry slice built from full_adder cells.
//   a_i, b_i : operand slices (b_i already inverted for subtraction)
//   ci_i     : carry into the slice LSB
//   s_o      : W-bit sum slice
//   co_o     : carry out of the slice MSB
//   cmsb_o   : carry into the slice MSB (signed-overflow tap on the top slice)
module add_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o,
  output logic         cmsb_o
);

  logic [W:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (c[i]),
      .s_o  (s_o[i]),
      .co_o (c[i+1])
    );
  end

  assign co_o   = c[W];
  assign cmsb_o = c[W-1];

endmodule

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined N-bit adder/subtractor, carry chain split into SEG
// registered segments of W = N/SEG bits. One operand pair per cycle under a
// valid/ready handshake; all stages advance in lockstep on en.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clr                  : synchronous flush of every in-flight operation
//   in_valid / in_ready  : operand handshake (in_ready = en)
//   a, b, sub            : operands; sub=1 computes a + ~b + 1
//   out_valid / out_ready: result handshake
//   sum, carry, ovf      : result, carry out of bit N-1, signed overflow
// Optional feature macro: PIPE_ADD_SUB_SAT_EN clamps sum to the signed range
// on overflow (carry and ovf stay raw).
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         ovf
);

  localparam int W = seg_width(N, SEG);

  if (!params_ok(N, SEG)) begin : g_bad_params
    $error("pipe_add_sub: N must be >= 2, 1 <= SEG <= N and N %% SEG == 0");
  end

  logic           en;
  logic [SEG-1:0] vld_q, vld_d;
  logic [SEG-1:0] cy_q;
  logic           ovf_q;
  logic [N-1:0]   a_q   [SEG];
  logic [N-1:0]   bx_q  [SEG];
  logic [N-1:0]   res_q [SEG];

  // Per-stage combinational view: operand/result words entering stage k.
  // Operands are shifted right by W each rank so a stage always adds bits
  // [W-1:0]; results are shifted right and the new slice enters at the top,
  // so after SEG ranks slice 0 has walked down to the LSB.
  logic [N-1:0]   a_st   [SEG];
  logic [N-1:0]   bx_st  [SEG];
  logic [N-1:0]   res_st [SEG];
  logic [N-1:0]   res_d  [SEG];
  logic [W-1:0]   s_st   [SEG];
  logic           cmsb_st[SEG];
  logic [SEG-1:0] cin_st, cout_st;
  logic           ovf_d;
  logic [N-1:0]   sum_d;

  assign en       = !vld_q[SEG-1] || out_ready;
  assign in_ready = en;
  assign vld_d    = (vld_q << 1) | SEG'(in_valid);

  for (genvar k = 0; k < SEG; k++) begin : g_st
    if (k == 0) begin : g_first
      assign a_st[k]   = a;
      assign bx_st[k]  = b ^ {N{sub}};
      assign cin_st[k] = sub;
      assign res_st[k] = '0;
    end else begin : g_next
      assign a_st[k]   = a_q[k-1];
      assign bx_st[k]  = bx_q[k-1];
      assign cin_st[k] = cy_q[k-1];
      assign res_st[k] = res_q[k-1];
    end

    add_segment #(.W(W)) u_seg (
      .a_i    (a_st[k][W-1:0]),
      .b_i    (bx_st[k][W-1:0]),
      .ci_i   (cin_st[k]),
      .s_o    (s_st[k]),
      .co_o   (cout_st[k]),
      .cmsb_o (cmsb_st[k])
    );

    assign res_d[k] = (res_st[k] >> W) | (N'(s_st[k]) << (N - W));
  end

  assign ovf_d = cmsb_st[SEG-1] ^ cout_st[SEG-1];

`ifdef PIPE_ADD_SUB_SAT_EN
  localparam logic [N-1:0] MAX_POS = N'(max_pos(N));
  localparam logic [N-1:0] MIN_NEG = N'(min_neg(N));

  // On overflow both operands share a sign; clamp toward that sign.
  function automatic logic [N-1:0] saturate(input logic [N-1:0] raw,
                                            input logic         o,
                                            input logic         sign);
    if (!o)
      return raw;
    return sign ? MIN_NEG : MAX_POS;
  endfunction

  // a_st[SEG-1][W-1] is original bit N-1 of operand a.
  assign sum_d = saturate(res_d[SEG-1], ovf_d, a_st[SEG-1][W-1]);
`else
  assign sum_d = res_d[SEG-1];
`endif

  // Stage boundary: every rank registers on en; clr only drops valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < SEG; k++) begin
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        res_q[k] <= '0;
      end
    end else begin
      if (clr)
        vld_q <= '0;
      else if (en)
        vld_q <= vld_d;
      if (en) begin
        cy_q  <= cout_st;
        ovf_q <= ovf_d;
        for (int k = 0; k < SEG; k++) begin
          a_q[k]   <= a_st[k] >> W;
          bx_q[k]  <= bx_st[k] >> W;
          res_q[k] <= (k == SEG - 1) ? sum_d : res_d[k];
        end
      end
    end
  end

  assign out_valid = vld_q[SEG-1];
  assign sum       = res_q[SEG-1];
  assign carry     = cy_q[SEG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
module tb_pipe_add_sub #(
  parameter int N   = 16,
  parameter int SEG = 4
);

  logic         clk = 1'b0;
  logic         rst_n, clr, in_valid, in_ready, sub, out_valid, out_ready;
  logic         carry, ovf;
  logic [N-1:0] a, b, sum;

  int vectors     = 0;
  int miscompares = 0;

  logic [N+1:0] sb[$];   // {carry, ovf, sum} expected, in order

  pipe_add_sub #(.N(N), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain N+1-bit arithmetic, overflow from operand/result signs.
  function automatic logic [N+1:0] model(input logic [N-1:0] av,
                                         input logic [N-1:0] bv,
                                         input logic         sv);
    logic [N-1:0] eb, r;
    logic [N:0]   full;
    logic         o;
    eb   = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, eb} + (N+1)'(sv);
    r    = full[N-1:0];
    o    = (av[N-1] == eb[N-1]) && (r[N-1] != av[N-1]);
`ifdef PIPE_ADD_SUB_SAT_EN
    if (o) r = av[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    return {full[N], o, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || sum !== '0 || carry !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b, expected all zero",
               out_valid, sum, carry, ovf);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tick();
  endtask

  // One isolated operation through an empty pipe; checks latency and result.
  task automatic send_one(input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic sv, input logic [N-1:0] es,
                          input logic ec, input logic eo, input string nm);
    int n;
    out_ready = 1'b1; in_valid = 1'b1; a = av; b = bv; sub = sv;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < SEG + 8) begin
      tick();
      n++;
    end
    vectors++;
    if (n != SEG) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d edges expected %0d", nm, n, SEG);
    end
    vectors++;
    if (out_valid !== 1'b1 || sum !== es || carry !== ec || ovf !== eo) begin
      miscompares++;
      $display("FAIL %s: got v=%b s=%h c=%b o=%b expected v=1 s=%h c=%b o=%b",
               nm, out_valid, sum, carry, ovf, es, ec, eo);
    end
    tick();
  endtask

  task automatic test_directed();
    logic [N-1:0] ones, one, maxp, minn, five;
    ones = '1; one = N'(1); five = N'(5);
    maxp = {1'b0, {(N-1){1'b1}}};
    minn = {1'b1, {(N-1){1'b0}}};
    send_one(ones, one, 1'b0, '0, 1'b1, 1'b0, "ones_plus_one");
`ifdef PIPE_ADD_SUB_SAT_EN
    send_one(maxp, one, 1'b0, maxp, 1'b0, 1'b1, "maxpos_plus_one");
    send_one(minn, one, 1'b1, minn, 1'b1, 1'b1, "minneg_minus_one");
`else
    send_one(maxp, one, 1'b0, minn, 1'b0, 1'b1, "maxpos_plus_one");
    send_one(minn, one, 1'b1, maxp, 1'b1, 1'b1, "minneg_minus_one");
`endif
    send_one('0, one, 1'b1, ones, 1'b0, 1'b0, "zero_minus_one");
    send_one(five, five, 1'b1, '0, 1'b1, 1'b0, "five_minus_five");
  endtask

  task automatic pick_operands();
    logic [N-1:0] corner[4];
    corner[0] = '0; corner[1] = '1;
    corner[2] = {1'b0, {(N-1){1'b1}}}; corner[3] = {1'b1, {(N-1){1'b0}}};
    a   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
    b   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic test_random();
    logic [N+1:0] exp, held;
    logic         hold_pend, ov, rdy, iv;
    int           pushed, guard;
    pushed = 0; guard = 0; hold_pend = 1'b0; held = '0;
    while ((pushed < 1000 || sb.size() > 0) && guard < 20000) begin
      guard++;
      if (hold_pend) begin
        vectors++;
        if (out_valid !== 1'b1 || {carry, ovf, sum} !== held) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b %h expected v=1 %h",
                   out_valid, {carry, ovf, sum}, held);
        end
      end
      ov  = out_valid;
      rdy = ($urandom_range(0, 3) != 0);
      iv  = (pushed < 1000) && ($urandom_range(0, 4) != 0);
      pick_operands();
      out_ready = rdy; in_valid = iv;
      #1;
      vectors++;
      if (in_ready !== (!ov || rdy)) begin
        miscompares++;
        $display("FAIL in_ready: got %b expected %b", in_ready, !ov || rdy);
      end
      if (ov && rdy) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL extra_result: got %h expected no result", {carry, ovf, sum});
        end else begin
          exp = sb.pop_front();
          if ({carry, ovf, sum} !== exp) begin
            miscompares++;
            $display("FAIL random_result: got %h expected %h", {carry, ovf, sum}, exp);
          end
        end
      end
      if (iv && (!ov || rdy)) begin
        sb.push_back(model(a, b, sub));
        pushed++;
      end
      hold_pend = ov && !rdy;
      held      = {carry, ovf, sum};
      tick();
    end
    vectors++;
    if (guard >= 20000) begin
      miscompares++;
      $display("FAIL random_timeout: got %0d pending expected 0", sb.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [N+1:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 40 + SEG; i++) begin
      vectors++;
      if (i < SEG) begin
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_fill: cycle %0d got v=%b expected 0", i, out_valid);
        end
      end else if (out_valid !== 1'b1 || sb.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_rate: cycle %0d got v=%b expected 1", i, out_valid);
      end else begin
        exp = sb.pop_front();
        if ({carry, ovf, sum} !== exp) begin
          miscompares++;
          $display("FAIL b2b_result: got %h expected %h", {carry, ovf, sum}, exp);
        end
      end
      in_valid = (i < 40);
      pick_operands();
      if (i < 40) sb.push_back(model(a, b, sub));
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    sb.delete();
  endtask

  task automatic test_clr();
    int m;
    m = (SEG - 1 < 3) ? SEG - 1 : 3;
    out_ready = 1'b1; clr = 1'b0;
    for (int i = 0; i < m; i++) begin
      in_valid = 1'b1; a = N'(i + 1); b = N'(2); sub = 1'b0;
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL clr_prefill: got v=%b expected 0", out_valid);
      end
    end
    in_valid = 1'b1; clr = 1'b1; a = N'(7); b = N'(7);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < SEG + 2; i++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL clr_flush: cycle %0d got v=%b expected 0", i, out_valid);
      end
      tick();
    end
    send_one(N'(3), N'(4), 1'b0, N'(7), 1'b0, 1'b0, "after_clr");
  endtask

  task automatic test_async_reset();
    int n;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = N'(i + 1); b = N'(2); sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < SEG + 4) begin
      tick();
      n++;
    end
    vectors++;
    if (out_valid !== 1'b1 || sum !== N'(3)) begin
      miscompares++;
      $display("FAIL pre_reset_hold: got v=%b s=%h expected v=1 s=%h", out_valid, sum, N'(3));
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || sum !== '0 || carry !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b s=%h c=%b o=%b expected all zero",
               out_valid, sum, carry, ovf);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_in_ready: got %b expected 1", in_ready);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < SEG + 2; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_empty: cycle %0d got v=%b expected 0", i, out_valid);
      end
    end
    send_one(N'(9), N'(1), 1'b1, N'(8), 1'b1, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
